// File: rtl/de10nano_pll_reset_sequencer_pkg.sv
// Shared definitions for the DE10-nano PLL reset sequencer: state encodings,
// retry counter width and a saturating increment helper.
package de10nano_pll_reset_sequencer_pkg;

   localparam int unsigned STATE_W = 2;
   localparam int unsigned RETRY_W = 8;

   typedef enum logic [STATE_W-1:0] {
      ST_PLL_RST   = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_STABLE    = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
      return (v == {RETRY_W{1'b1}}) ? v : v + RETRY_W'(1);
   endfunction

endpackage

// File: rtl/rstseq_sync2.sv
// Two-flop synchroniser for the asynchronous PLL 'locked' signal.
module rstseq_sync2 (
   input  logic clock,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   (* ASYNC_REG = "TRUE", keep = "true" *) logic meta;
   (* ASYNC_REG = "TRUE", keep = "true" *) logic stage2;

   // Two back-to-back flops, cleared by the synchronous reset.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         meta   <= 1'b0;
         stage2 <= 1'b0;
      end else begin
         meta   <= d;
         stage2 <= meta;
      end
   end

   assign q = stage2;

endmodule

// File: rtl/de10nano_pll_reset_sequencer.sv
// PLL supervisor: pulses the PLL reset, waits for a stable lock, then releases
// the system reset; retries on lock timeout and drops reset on lock loss.
// Optional status (retries counter, lost_lock sticky) enabled by macro
// RSTSEQ_STATUS_EN; when undefined those ports are tied to 0.
module de10nano_pll_reset_sequencer
   import de10nano_pll_reset_sequencer_pkg::*;
#(
   parameter int unsigned PLL_RST_CYCLES = 16,
   parameter int unsigned LOCK_TIMEOUT   = 500000,
   parameter int unsigned STABLE_CYCLES  = 1024,
   parameter int unsigned CNT_W          = 20
) (
   input  logic               clock,
   input  logic               rst_n,
   input  logic               locked_async,
   output logic               pll_rst,
   output logic               sys_rst_n,
   output logic               ready,
   output logic [RETRY_W-1:0] retries,
   output logic               lost_lock
);

   localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             locked_s;
   logic             pll_rst_n, run_n;
   logic             retry_inc, lost_set;

   rstseq_sync2 u_sync (
      .clock (clock),
      .rst_n (rst_n),
      .d     (locked_async),
      .q     (locked_s)
   );

   // State, shared counter and registered outputs.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state     <= ST_PLL_RST;
         cnt       <= '0;
         pll_rst   <= 1'b1;
         sys_rst_n <= 1'b0;
         ready     <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         pll_rst   <= pll_rst_n;
         sys_rst_n <= run_n;
         ready     <= run_n;
      end
   end

   // Next-state, counter and output decode; outputs follow the next state.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      retry_inc = 1'b0;
      lost_set  = 1'b0;
      unique case (state)
         ST_PLL_RST: begin
            if (cnt == PLL_LAST) begin
               state_n = ST_WAIT_LOCK;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         ST_WAIT_LOCK: begin
            if (locked_s) begin
               state_n = ST_STABLE;
               cnt_n   = '0;
            end else if (cnt == TIMEOUT_LAST) begin
               state_n   = ST_PLL_RST;
               cnt_n     = '0;
               retry_inc = 1'b1;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         ST_STABLE: begin
            if (!locked_s) begin
               state_n = ST_WAIT_LOCK;
               cnt_n   = '0;
            end else if (cnt == STABLE_LAST) begin
               state_n = ST_RUN;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         ST_RUN: begin
            if (!locked_s) begin
               state_n  = ST_WAIT_LOCK;
               cnt_n    = '0;
               lost_set = 1'b1;
            end
         end
         default: begin
            state_n = ST_PLL_RST;
            cnt_n   = '0;
         end
      endcase
      pll_rst_n = (state_n == ST_PLL_RST);
      run_n     = (state_n == ST_RUN);
   end

`ifdef RSTSEQ_STATUS_EN
   // Saturating retry counter and sticky lost-lock flag.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         retries   <= '0;
         lost_lock <= 1'b0;
      end else begin
         if (retry_inc) retries <= sat_inc(retries);
         if (lost_set)  lost_lock <= 1'b1;
      end
   end
`else
   logic unused_status;
   assign unused_status = retry_inc ^ lost_set;
   assign retries       = '0;
   assign lost_lock     = 1'b0;
`endif

endmodule

// File: tb/tb_de10nano_pll_reset_sequencer.sv
// Directed bench for de10nano_pll_reset_sequencer (PLL_RST_CYCLES=4,
// LOCK_TIMEOUT=32, STABLE_CYCLES=8). Status expectations follow RSTSEQ_STATUS_EN.
module tb_de10nano_pll_reset_sequencer;

`ifdef RSTSEQ_STATUS_EN
   localparam bit STATUS_EN = 1'b1;
`else
   localparam bit STATUS_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       locked_async;
   logic       pll_rst;
   logic       sys_rst_n;
   logic       ready;
   logic [7:0] retries;
   logic       lost_lock;

   int n_tests = 0;
   int n_fail  = 0;

   de10nano_pll_reset_sequencer #(
      .PLL_RST_CYCLES (4),
      .LOCK_TIMEOUT   (32),
      .STABLE_CYCLES  (8),
      .CNT_W          (20)
   ) dut (
      .clock        (clk),
      .rst_n        (rst_n),
      .locked_async (locked_async),
      .pll_rst      (pll_rst),
      .sys_rst_n    (sys_rst_n),
      .ready        (ready),
      .retries      (retries),
      .lost_lock    (lost_lock)
   );

   always #5 clk = ~clk;

   // Advance one clock edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_pll_rst"},   32'(pll_rst),   32'd1);
      check({tag, "_sys_rst_n"}, 32'(sys_rst_n), 32'd0);
      check({tag, "_ready"},     32'(ready),     32'd0);
      check({tag, "_retries"},   32'(retries),   32'd0);
      check({tag, "_lost_lock"}, 32'(lost_lock), 32'd0);
   endtask

   initial begin
      int exp_r;
      rst_n        = 1'b0;
      locked_async = 1'b0;
      repeat (3) tick();
      check_reset_state("rst");

      // 1: release, PLL reset for 4 edges, lock at edge 10, RUN 11 edges later
      rst_n = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         tick();
         check("t1_pll_rst", 32'(pll_rst), 32'(e < 4));
      end
      repeat (5) tick();
      locked_async = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         tick();
         check("t1_sys_rst_n", 32'(sys_rst_n), 32'(i == 11));
         check("t1_ready", 32'(ready), 32'(i == 11));
      end

      // 4: lose lock in RUN, reset drops 3 edges later, relock
      repeat (3) tick();
      check("t4_run", 32'(sys_rst_n), 32'd1);
      locked_async = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check("t4_sys_rst_n", 32'(sys_rst_n), 32'(i < 3));
         check("t4_ready", 32'(ready), 32'(i < 3));
      end
      check("t4_lost_lock", 32'(lost_lock), 32'(STATUS_EN));
      locked_async = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         tick();
         check("t4_relock", 32'(sys_rst_n), 32'(i == 11));
      end
      check("t4_lost_sticky", 32'(lost_lock), 32'(STATUS_EN));
      check("t4_retries", 32'(retries), 32'd0);

      // 3: drop lock for 3 cycles while STABLE at cnt=5
      locked_async = 1'b0;
      repeat (3) tick();
      check("t3_wait", 32'(sys_rst_n), 32'd0);
      locked_async = 1'b1;
      repeat (8) tick();
      locked_async = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check("t3_glitch", 32'(sys_rst_n), 32'd0);
      end
      locked_async = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         tick();
         check("t3_restart", 32'(sys_rst_n), 32'(i == 11));
      end
      check("t3_retries", 32'(retries), 32'd0);

      // 5: reset mid-STABLE wins and restarts from PLL_RST
      locked_async = 1'b0;
      repeat (3) tick();
      locked_async = 1'b1;
      repeat (6) tick();
      rst_n = 1'b0;
      tick();
      check_reset_state("t5");
      rst_n = 1'b1;
      for (int e = 1; e <= 13; e++) begin
         tick();
         check("t5_pll_rst", 32'(pll_rst), 32'(e < 4));
         check("t5_sys_rst_n", 32'(sys_rst_n), 32'(e == 13));
      end

      // 2: no lock, retry every 36 cycles, retries saturate at 255
      locked_async = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int e = 1; e <= 36 * 257 + 8; e++) begin
         tick();
         exp_r = e / 36;
         if (exp_r > 255) exp_r = 255;
         if (!STATUS_EN) exp_r = 0;
         check("t2_retries", 32'(retries), 32'(exp_r));
         if (e <= 200) begin
            check("t2_pll_rst", 32'(pll_rst), 32'((e < 4) || (((e - 4) % 36) >= 32)));
            check("t2_sys_rst_n", 32'(sys_rst_n), 32'd0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
